mult_pipe: RTL and testbench

Parametrised, fully pipelined multiplier with AXI-stream handshakes on both operand inputs and the product output. Multiplies two W-bit operands into a 2W-bit product with a configurable pipeline depth. Per-stage valid tracking and a global stall give correct backpressure. It serves as the general multiplier primitive for the ElGamal datapath (modular multiply/exponentiate units) and supersedes the fixed 16x16 multiplier.

---
 rtl/mult_pipe.sv | 77 +++++++
 tb/tb_mult_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_pipe                                                                  |
// | Pipelined SIZE/2 x SIZE/2 -> SIZE multiplier with AXI-stream join input,   |
// | global-stall backpressure. Define MULT_PIPE_SIGNED_EN for signed operands. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mult_pipe #(
  parameter int SIZE   = 32,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE/2-1:0] input_a_tdata,
  input  logic              input_a_tvalid,
  output logic              input_a_tready,
  input  logic [SIZE/2-1:0] input_b_tdata,
  input  logic              input_b_tvalid,
  output logic              input_b_tready,
  output logic [SIZE-1:0]   output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready,
  output logic              busy
);

  localparam int W = SIZE / 2;

  logic              adv;
  logic              accept;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [STAGES:1]   v_q;
  logic [STAGES:1]   v_d;
  logic [SIZE-1:0]   prod_d;
  logic [SIZE-1:0]   prod_q [2:STAGES];

  // Whole pipe moves as one; treadys are held low while in reset.
  assign adv            = ~v_q[STAGES] | output_tready;
  assign accept         = input_a_tvalid & input_b_tvalid & adv & ~rst;
  assign input_a_tready = input_b_tvalid & adv & ~rst;
  assign input_b_tready = input_a_tvalid & adv & ~rst;

`ifdef MULT_PIPE_SIGNED_EN
  assign prod_d = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
`else
  assign prod_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
`endif

  always_comb begin
    v_d = {v_q[STAGES-1:1], accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= '0;
      for (int s = 2; s <= STAGES; s++) begin
        prod_q[s] <= '0;
      end
    end else if (adv) begin
      a_q       <= input_a_tdata;
      b_q       <= input_b_tdata;
      v_q       <= v_d;
      prod_q[2] <= prod_d;
      for (int s = 3; s <= STAGES; s++) begin
        prod_q[s] <= prod_q[s-1];
      end
    end
  end

  assign output_tdata  = prod_q[STAGES];
  assign output_tvalid = v_q[STAGES];
  assign busy          = |v_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult_pipe                                                               |
// | Randomised bench for mult_pipe against a queue-based latency model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mult_pipe;

  localparam int SIZE   = 32;
  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] input_a_tdata = '0;
  logic        input_a_tvalid = 1'b0;
  logic        input_a_tready;
  logic [15:0] input_b_tdata = '0;
  logic        input_b_tvalid = 1'b0;
  logic        input_b_tready;
  logic [31:0] output_tdata;
  logic        output_tvalid;
  logic        output_tready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  int n_pop    = 0;
  bit last_acc;

  // Model: each in-flight product with the number of advancing edges it still needs.
  logic [31:0] pq[$];
  int          rq[$];

  mult_pipe #(.SIZE(SIZE), .STAGES(STAGES)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_a_tdata  (input_a_tdata),
    .input_a_tvalid (input_a_tvalid),
    .input_a_tready (input_a_tready),
    .input_b_tdata  (input_b_tdata),
    .input_b_tvalid (input_b_tvalid),
    .input_b_tready (input_b_tready),
    .output_tdata   (output_tdata),
    .output_tvalid  (output_tvalid),
    .output_tready  (output_tready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_PIPE_SIGNED_EN
    int sa;
    int sb;
    sa = int'(shortint'(a));
    sb = int'(shortint'(b));
    return 32'(sa * sb);
`else
    longint ua;
    longint ub;
    ua = longint'(a);
    ub = longint'(b);
    return 32'(ua * ub);
`endif
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit av, input logic [15:0] a, input bit bv,
                       input logic [15:0] b, input bit rdy);
    bit ev;
    bit adv;
    input_a_tvalid = av;
    input_a_tdata  = a;
    input_b_tvalid = bv;
    input_b_tdata  = b;
    output_tready  = rdy;
    #1;
    ev  = (rq.size() > 0) && (rq[0] == 0);
    adv = !ev || rdy;
    check_eq("a_tready", input_a_tready, bv && adv);
    check_eq("b_tready", input_b_tready, av && adv);
    check_eq("out_valid", output_tvalid, ev);
    if (ev) check_eq("out_data", output_tdata, pq[0]);
    check_eq("busy", busy, rq.size() != 0);
    if (output_tvalid && rdy) n_out++;
    @(posedge clk);
    if (adv) begin
      if (ev) begin
        void'(pq.pop_front());
        void'(rq.pop_front());
        n_pop++;
      end
      foreach (rq[i]) rq[i] = rq[i] - 1;
      if (av && bv) begin
        pq.push_back(ref_mul(a, b));
        rq.push_back(STAGES - 1);
      end
    end
    last_acc = av && bv && adv;
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int g = 0;
    while (rq.size() > 0 && g < max_cycles) begin
      cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      g++;
    end
    check_eq("drain_empty", rq.size(), 0);
  endtask

  initial begin
    logic [15:0] ba [10];
    logic [15:0] bb [10];
    int idx;
    int guard;

    // Reset state, with both valids high to show treadys stay low.
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
    output_tready  = 1'b1;
    #12;
    check_eq("rst_out_valid", output_tvalid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_out_data", output_tdata, 32'h0);
    check_eq("rst_a_tready", input_a_tready, 1'b0);
    check_eq("rst_b_tready", input_b_tready, 1'b0);
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic
    cycle(1'b1, 16'd3, 1'b1, 16'd5, 1'b1);
    check_eq("basic_acc", last_acc, 1'b1);
    repeat (4) cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    // Max operands
    cycle(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    cycle(1'b1, 16'hFFFF, 1'b1, 16'h0002, 1'b1);
    drain(10);

    // Streaming: every beat must be taken with ready high
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1);
      check_eq("stream_acc", last_acc, 1'b1);
    end
    drain(10);

    // Backpressure with source holding each pair until accepted
    for (int i = 0; i < 10; i++) begin
      ba[i] = 16'($urandom);
      bb[i] = 16'($urandom);
    end
    idx   = 0;
    guard = 0;
    while ((idx < 10 || rq.size() > 0) && guard < 300) begin
      if (idx < 10) cycle(1'b1, ba[idx], 1'b1, bb[idx], 1'($urandom_range(0, 1)));
      else          cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      if (last_acc) idx++;
      guard++;
    end
    check_eq("bp_all_sent", idx, 10);
    check_eq("bp_all_out", rq.size(), 0);

    // Join: lone A must wait for B
    repeat (4) begin
      cycle(1'b1, 16'd7, 1'b0, 16'h0, 1'b1);
      check_eq("join_wait", last_acc, 1'b0);
    end
    cycle(1'b1, 16'd7, 1'b1, 16'd6, 1'b1);
    check_eq("join_acc", last_acc, 1'b1);
    drain(10);

    // Reset mid-operation with the output stalled
    cycle(1'b1, 16'd2, 1'b1, 16'd3, 1'b0);
    cycle(1'b1, 16'd4, 1'b1, 16'd5, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_out_valid", output_tvalid, 1'b0);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_out_data", output_tdata, 32'h0);
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
    output_tready  = 1'b1;
    #1;
    check_eq("mrst_a_tready", input_a_tready, 1'b0);
    check_eq("mrst_b_tready", input_b_tready, 1'b0);
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    pq.delete();
    rq.delete();
    rst = 1'b0;
    @(negedge clk);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'd2, 1'b1, 16'd9, 1'b1);
    repeat (4) cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    check_eq("out_count", n_out, n_pop);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
